// File: rtl/led_seq_pkg.sv
// ============================================================================
// led_seq_pkg: shared types and table geometry for the LED sequencer. rev 1.0
// ============================================================================
`default_nettype none

package led_seq_pkg;

  localparam int DEPTH = 8;
  localparam int DUR_W = 16;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0]       pattern;
    logic [DUR_W-1:0] dur;
  } step_t;

endpackage

`default_nettype wire

// File: rtl/led_sequencer_tick_prescaler.sv
// ============================================================================
// tick_prescaler: divides clk by DIV, one-cycle tick on the last count. rev 1.0
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/led_sequencer.sv
// ============================================================================
// led_sequencer: walks a (pattern, duration) table on a prescaled tick. rev 1.0
// ============================================================================
`default_nettype none

module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_HZ  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [7:0]       cfg_pattern,
  input  logic [DUR_W-1:0] cfg_dur,
  input  logic [IDX_W-1:0] cfg_last,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             done,
  output logic [7:0]       leds
);

  localparam int DIV = CLK_FREQ / TICK_HZ;

  state_e           state_q, state_d;
  step_t            table_q [DEPTH];
  step_t            table_d [DEPTH];
  logic [7:0]       leds_q, leds_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] load_idx;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_en;
  logic             tick;

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  always_comb begin
    table_d = table_q;
    if (cfg_we) begin
      table_d[cfg_addr] = '{pattern: cfg_pattern, dur: cfg_dur};
    end
  end

  always_comb begin
    state_d  = state_q;
    leds_d   = leds_q;
    idx_d    = idx_q;
    last_d   = last_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_en  = 1'b0;
    load_idx = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          last_d  = cfg_last;
          busy_d  = 1'b1;
          load_en = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // stop outranks any tick landing in the same cycle
        if (stop) begin
          leds_d  = '0;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (rem_q > DUR_W'(1)) begin
            rem_d = rem_q - 1'b1;
          end else if (idx_q != last_q) begin
            load_en  = 1'b1;
            load_idx = idx_q + 1'b1;
          end else if (loop_en) begin
            load_en = 1'b1;
          end else begin
            leds_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // reads the pre-write table, so a same-cycle write is not seen by the load
    if (load_en) begin
      leds_d = table_q[load_idx].pattern;
      idx_d  = load_idx;
      rem_d  = (table_q[load_idx].dur == '0) ? DUR_W'(1) : table_q[load_idx].dur;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      leds_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      leds_q  <= leds_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
    end
  end

  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_led_sequencer.sv
// ============================================================================
// tb_led_sequencer: directed + random stimulus against a clock-count model. rev 1.0
// ============================================================================
`default_nettype none

module tb_led_sequencer;
  import led_seq_pkg::*;

  localparam int DIV = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [7:0]       cfg_pattern = '0;
  logic [DUR_W-1:0] cfg_dur = '0;
  logic [IDX_W-1:0] cfg_last = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             busy;
  logic [IDX_W-1:0] step_idx;
  logic             done;
  logic [7:0]       leds;

  int checks = 0;
  int failures = 0;
  int busy_cyc = 0;
  int done_cyc = 0;

  // Model works in whole clocks per step rather than ticks.
  logic [7:0] m_pat [DEPTH];
  int         m_dur [DEPTH];
  logic [7:0] m_leds;
  logic       m_busy;
  logic       m_done;
  int         m_idx;
  int         m_last;
  int         m_left;

  always #5 clk = ~clk;

  led_sequencer #(
    .CLK_FREQ (100),
    .TICK_HZ  (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_pattern (cfg_pattern),
    .cfg_dur     (cfg_dur),
    .cfg_last    (cfg_last),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .step_idx    (step_idx),
    .done        (done),
    .leds        (leds)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_pat[i] = 8'h00;
      m_dur[i] = 0;
    end
    m_leds = 8'h00; m_busy = 1'b0; m_done = 1'b0;
    m_idx = 0; m_last = 0; m_left = 0;
  endtask

  task automatic model_load(input int i);
    m_idx  = i;
    m_leds = m_pat[i];
    m_left = ((m_dur[i] == 0) ? 1 : m_dur[i]) * DIV;
  endtask

  // Applies one clock edge using the inputs that were stable before it.
  task automatic model_edge();
    logic done_n;
    done_n = 1'b0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (start && !stop) begin
        m_last = int'(cfg_last);
        m_busy = 1'b1;
        model_load(0);
      end
    end else if (stop) begin
      m_leds = 8'h00; m_busy = 1'b0; m_idx = 0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_idx != m_last) model_load((m_idx + 1) % DEPTH);
        else if (loop_en) model_load(0);
        else begin
          m_leds = 8'h00; m_busy = 1'b0; done_n = 1'b1;
        end
      end
    end
    m_done = done_n;
    if (cfg_we) begin
      m_pat[cfg_addr] = cfg_pattern;
      m_dur[cfg_addr] = int'(cfg_dur);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      check("leds", 32'(leds), 32'(m_leds));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("step_idx", 32'(step_idx), 32'(m_idx));
      if (busy) busy_cyc++;
      if (done) done_cyc++;
    end
  endtask

  task automatic wr(input int addr, input logic [7:0] pat, input int dur);
    cfg_we = 1'b1; cfg_addr = IDX_W'(addr); cfg_pattern = pat; cfg_dur = DUR_W'(dur);
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // left < 0 means any remaining count
  task automatic run_until(input int idx, input int left, input int budget);
    int k;
    k = 0;
    while (!(m_busy && m_idx == idx && (left < 0 || m_left == left)) && k < budget) begin
      cyc();
      k++;
    end
    check("wait_step_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      cyc();
      k++;
    end
    check("wait_idle_timeout", 32'(k < budget), 32'd1);
  endtask

  initial begin
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // basic three-step sequence, no loop
    wr(0, 8'h01, 2); wr(1, 8'h02, 1); wr(2, 8'h04, 3);
    cfg_last = 3'd2; loop_en = 1'b0;
    busy_cyc = 0; done_cyc = 0;
    pulse_start();
    cyc(69);
    check("basic_busy_clocks", 32'(busy_cyc), 32'd60);
    check("basic_done_pulses", 32'(done_cyc), 32'd1);

    // looping, then drop loop_en during the last step
    loop_en = 1'b1; done_cyc = 0;
    pulse_start();
    cyc(64);
    check("loop_wrapped_leds", 32'(leds), 32'h01);
    check("loop_no_done", 32'(done_cyc), 32'd0);
    run_until(2, -1, 100);
    loop_en = 1'b0;
    run_until_idle(100);
    cyc(2);
    check("loop_end_done", 32'(done_cyc), 32'd1);

    // zero duration, single step
    wr(0, 8'h3C, 0);
    cfg_last = 3'd0; busy_cyc = 0;
    pulse_start();
    cyc(14);
    check("zero_dur_clocks", 32'(busy_cyc), 32'd10);

    // stop in step 1
    wr(0, 8'h01, 2);
    cfg_last = 3'd2; done_cyc = 0;
    pulse_start();
    run_until(1, -1, 50);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check("stop_leds_dark", 32'(leds), 32'h00);
    cyc(5);
    check("stop_no_done", 32'(done_cyc), 32'd0);

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    cyc(3);
    check("start_stop_idle", 32'(busy), 32'd0);

    // start while running must not restart
    pulse_start();
    cyc(7);
    pulse_start();
    cyc(20);
    pulse_start();
    run_until_idle(100);
    cyc(2);

    // live edits while looping
    loop_en = 1'b1;
    pulse_start();
    run_until(1, -1, 50);
    wr(1, 8'hFF, 1);
    check("live_edit_current", 32'(leds), 32'h02);
    run_until(2, 1, 100);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_pattern = 8'h77; cfg_dur = 16'd2;
    cyc();
    cfg_we = 1'b0;
    check("edit_at_load_old", 32'(leds), 32'h01);
    run_until(1, -1, 50);
    check("live_edit_next_pass", 32'(leds), 32'hFF);
    run_until(2, -1, 50);
    run_until(0, -1, 100);
    check("edit0_next_pass", 32'(leds), 32'h77);
    stop = 1'b1;
    cyc();
    stop = 1'b0;

    // asynchronous reset mid-run
    wr(0, 8'hA5, 5);
    cfg_last = 3'd0;
    pulse_start();
    cyc(5);
    check("pre_reset_leds", 32'(leds), 32'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_leds", 32'(leds), 32'h00);
    check("async_reset_busy", 32'(busy), 32'd0);
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // randomized traffic
    loop_en = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_addr    = IDX_W'($urandom);
      cfg_pattern = 8'($urandom);
      cfg_dur     = DUR_W'($urandom_range(0, 3));
      start       = ($urandom_range(0, 15) == 0);
      stop        = ($urandom_range(0, 99) == 0);
      cfg_last    = IDX_W'($urandom);
      if ($urandom_range(0, 31) == 0) loop_en = 1'($urandom);
      cyc();
    end
    cfg_we = 1'b0; start = 1'b0; stop = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
